// File: rtl/mem_burst_arbiter.sv
// Two-requester round-robin arbiter and burst sequencer for the single
// data-memory port. One burst runs at a time, one word per cycle, with the
// address incrementing modulo 2^ADDR_W. Beat/done strobes go back to the owner.
module mem_burst_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [LEN_W-1:0]  req_len0,
  input  logic [LEN_W-1:0]  req_len1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        req_ack,
  output logic [1:0]        beat,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              owner_q;
  logic              we_q;
  logic              first_q;
  logic              last_owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  count_q;

  logic              any_req;
  logic              grant;
  logic              last_word;
  logic [LEN_W-1:0]  sel_len;
  logic [1:0]        owner_mask;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    any_req    = |req_valid;
    grant      = (req_valid == 2'b11) ? ~last_owner_q : req_valid[1];
    sel_len    = grant ? req_len1 : req_len0;
    last_word  = (count_q == LEN_W'(1));
    owner_mask = owner_q ? 2'b10 : 2'b01;
  end

  // State register; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_XFER;
      S_XFER:  if (last_word) state_d = we_q ? S_IDLE : S_DRAIN;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Burst context: latched at grant, advanced once per transferred word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      first_q      <= 1'b0;
      last_owner_q <= 1'b1;
      addr_q       <= '0;
      count_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q      <= grant;
            last_owner_q <= grant;
            we_q         <= req_we[grant];
            addr_q       <= grant ? req_addr1 : req_addr0;
            count_q      <= (sel_len == '0) ? LEN_W'(1) : sel_len;
            first_q      <= 1'b1;
          end
        end
        S_XFER: begin
          first_q <= 1'b0;
          addr_q  <= addr_q + ADDR_W'(1);
          if (!last_word) count_q <= count_q - LEN_W'(1);
        end
        default: first_q <= 1'b0;
      endcase
    end
  end

  // Output decode from the registered state; reads return one cycle after mem_re.
  always_comb begin
    req_ack   = 2'b00;
    beat      = 2'b00;
    done      = 2'b00;
    rdata     = '0;
    busy      = 1'b0;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      S_XFER: begin
        busy     = 1'b1;
        mem_addr = addr_q;
        if (first_q) req_ack = owner_mask;
        if (we_q) begin
          mem_we    = 1'b1;
          mem_wdata = owner_q ? wdata1 : wdata0;
          beat      = owner_mask;
          if (last_word) done = owner_mask;
        end else begin
          mem_re = 1'b1;
          if (!first_q) begin
            beat  = owner_mask;
            rdata = mem_rdata;
          end
        end
      end
      S_DRAIN: begin
        busy  = 1'b1;
        beat  = owner_mask;
        done  = owner_mask;
        rdata = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule
